// File: rtl/uart_rx_controller.sv
// Sequencing controller for the 16x-baud UART receive processor: frame-format
// configuration applied on an idle line, frame capture into a valid/ready FIFO.
module uart_rx_controller #(
    parameter int         DEPTH            = 8,
    parameter int         IDLE_TICKS       = 176,
    parameter logic [3:0] DEF_FRAME_LENGTH = 4'd8
) (
    input  logic       clk_16bd,
    input  logic       rst,
    input  logic       Rx,
    input  logic [8:0] frame,
    input  logic       frame_valid,
    input  logic       cfg_req,
    input  logic       cfg_parity,
    input  logic       cfg_parity_type,
    input  logic       cfg_stop_bits,
    input  logic [3:0] cfg_frame_length,
    output logic       cfg_busy,
    output logic       cfg_ack,
    output logic       cfg_err,
    output logic       parity,
    output logic       parity_type,
    output logic       stop_bits,
    output logic [3:0] frame_length,
    output logic       proc_rst,
    output logic [8:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun,
    input  logic       overrun_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(IDLE_TICKS + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TICKS - 1);

    typedef enum logic [1:0] {RUN, WAIT_IDLE, APPLY} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          pend_parity_q, pend_parity_d;
    logic          pend_parity_type_q, pend_parity_type_d;
    logic          pend_stop_bits_q, pend_stop_bits_d;
    logic [3:0]    pend_frame_length_q, pend_frame_length_d;
    logic          parity_q, parity_d;
    logic          parity_type_q, parity_type_d;
    logic          stop_bits_q, stop_bits_d;
    logic [3:0]    frame_length_q, frame_length_d;
    logic          cfg_ack_q, cfg_ack_d;
    logic          cfg_err_q, cfg_err_d;
    logic          proc_rst_q, proc_rst_d;
    logic          fv_q, fv_d;
    logic          overrun_q, overrun_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [8:0]    mem_q [DEPTH];
    logic [8:0]    mem_d [DEPTH];

    logic       capture, full, empty, push, pop, drop, apply_pulse, len_legal;
    logic [8:0] mask, masked_frame;

    assign capture   = frame_valid & ~fv_q;
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign pop       = ~empty & out_ready;
    assign push      = capture & (~full | pop);
    assign drop      = capture & full & ~pop;
    assign len_legal = (cfg_frame_length >= 4'd5) && (cfg_frame_length <= 4'd9);

    always_comb begin
        mask = '0;
        for (int i = 0; i < 9; i++) begin
            mask[i] = (i < int'(frame_length_q));
        end
        masked_frame = frame & mask;
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = masked_frame;
        end
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        overrun_d = drop | (overrun_q & ~overrun_clr);
        fv_d      = frame_valid;
    end

    // New config lands on the edge entering APPLY so it is visible alongside cfg_ack.
    always_comb begin
        state_d             = state_q;
        idle_cnt_d          = idle_cnt_q;
        pend_parity_d       = pend_parity_q;
        pend_parity_type_d  = pend_parity_type_q;
        pend_stop_bits_d    = pend_stop_bits_q;
        pend_frame_length_d = pend_frame_length_q;
        parity_d            = parity_q;
        parity_type_d       = parity_type_q;
        stop_bits_d         = stop_bits_q;
        frame_length_d      = frame_length_q;
        cfg_ack_d           = 1'b0;
        cfg_err_d           = 1'b0;
        apply_pulse         = 1'b0;
        case (state_q)
            RUN: begin
                if (cfg_req) begin
                    if (len_legal) begin
                        pend_parity_d       = cfg_parity;
                        pend_parity_type_d  = cfg_parity_type;
                        pend_stop_bits_d    = cfg_stop_bits;
                        pend_frame_length_d = cfg_frame_length;
                        idle_cnt_d          = '0;
                        state_d             = WAIT_IDLE;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (!Rx) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d        = APPLY;
                    cfg_ack_d      = 1'b1;
                    apply_pulse    = 1'b1;
                    parity_d       = pend_parity_q;
                    parity_type_d  = pend_parity_type_q;
                    stop_bits_d    = pend_stop_bits_q;
                    frame_length_d = pend_frame_length_q;
                end else if (idle_cnt_q != '1) begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
            end
            APPLY:   state_d = RUN;
            default: state_d = RUN;
        endcase
        proc_rst_d = capture | apply_pulse;
    end

    always_ff @(posedge clk_16bd) begin
        if (rst) begin
            state_q             <= RUN;
            idle_cnt_q          <= '0;
            pend_parity_q       <= 1'b0;
            pend_parity_type_q  <= 1'b0;
            pend_stop_bits_q    <= 1'b0;
            pend_frame_length_q <= DEF_FRAME_LENGTH;
            parity_q            <= 1'b0;
            parity_type_q       <= 1'b0;
            stop_bits_q         <= 1'b0;
            frame_length_q      <= DEF_FRAME_LENGTH;
            cfg_ack_q           <= 1'b0;
            cfg_err_q           <= 1'b0;
            proc_rst_q          <= 1'b1;
            fv_q                <= 1'b0;
            overrun_q           <= 1'b0;
            wr_ptr_q            <= '0;
            rd_ptr_q            <= '0;
            count_q             <= '0;
            mem_q               <= '{default: '0};
        end else begin
            state_q             <= state_d;
            idle_cnt_q          <= idle_cnt_d;
            pend_parity_q       <= pend_parity_d;
            pend_parity_type_q  <= pend_parity_type_d;
            pend_stop_bits_q    <= pend_stop_bits_d;
            pend_frame_length_q <= pend_frame_length_d;
            parity_q            <= parity_d;
            parity_type_q       <= parity_type_d;
            stop_bits_q         <= stop_bits_d;
            frame_length_q      <= frame_length_d;
            cfg_ack_q           <= cfg_ack_d;
            cfg_err_q           <= cfg_err_d;
            proc_rst_q          <= proc_rst_d;
            fv_q                <= fv_d;
            overrun_q           <= overrun_d;
            wr_ptr_q            <= wr_ptr_d;
            rd_ptr_q            <= rd_ptr_d;
            count_q             <= count_d;
            mem_q               <= mem_d;
        end
    end

    assign cfg_busy     = (state_q != RUN);
    assign cfg_ack      = cfg_ack_q;
    assign cfg_err      = cfg_err_q;
    assign parity       = parity_q;
    assign parity_type  = parity_type_q;
    assign stop_bits    = stop_bits_q;
    assign frame_length = frame_length_q;
    assign proc_rst     = proc_rst_q;
    assign out_valid    = ~empty;
    assign out_data     = empty ? 9'h000 : mem_q[rd_ptr_q];
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Scenario-per-task bench for uart_rx_controller; expected frames are queued
// when a capture is driven and compared as the FIFO drains.
module tb_uart_rx_controller;

    logic       clk_16bd = 1'b0;
    logic       rst = 1'b0;
    logic       Rx = 1'b1;
    logic [8:0] frame = '0;
    logic       frame_valid = 1'b0;
    logic       cfg_req = 1'b0;
    logic       cfg_parity = 1'b0;
    logic       cfg_parity_type = 1'b0;
    logic       cfg_stop_bits = 1'b0;
    logic [3:0] cfg_frame_length = 4'd8;
    logic       cfg_busy, cfg_ack, cfg_err;
    logic       parity, parity_type, stop_bits;
    logic [3:0] frame_length;
    logic       proc_rst;
    logic [8:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       overrun;
    logic       overrun_clr = 1'b0;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    int         cur_len = 8;

    uart_rx_controller dut (
        .clk_16bd(clk_16bd), .rst(rst), .Rx(Rx), .frame(frame), .frame_valid(frame_valid),
        .cfg_req(cfg_req), .cfg_parity(cfg_parity), .cfg_parity_type(cfg_parity_type),
        .cfg_stop_bits(cfg_stop_bits), .cfg_frame_length(cfg_frame_length),
        .cfg_busy(cfg_busy), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
        .parity(parity), .parity_type(parity_type), .stop_bits(stop_bits),
        .frame_length(frame_length), .proc_rst(proc_rst), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk_16bd = ~clk_16bd;

    task automatic tick();
        @(posedge clk_16bd);
        #1;
    endtask

    function automatic logic [8:0] model_mask(input logic [8:0] f, input int len);
        logic [8:0] ones;
        ones = 9'h1FF;
        return f & ~(ones << len);
    endfunction

    // Drives one frame_valid rising edge; returns after frame_valid is back low.
    task automatic send_frame(input logic [8:0] f, input bit expect_push);
        frame = f;
        frame_valid = 1'b1;
        if (expect_push) exp_q.push_back(model_mask(f, cur_len));
        tick();
        frame_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (proc_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset_proc_rst got %b want 1", proc_rst); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 9'h000) begin errors++; $display("[TB] FAIL reset_out_data got %h want 000", out_data); end
        checks++; if ({parity, parity_type, stop_bits, frame_length} !== 7'b000_1000) begin
            errors++; $display("[TB] FAIL reset_config got %b want 0001000", {parity, parity_type, stop_bits, frame_length}); end
        checks++; if ({cfg_busy, cfg_ack, cfg_err, overrun} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_flags got %b want 0000", {cfg_busy, cfg_ack, cfg_err, overrun}); end
        tick();
        checks++; if (proc_rst !== 1'b0) begin errors++; $display("[TB] FAIL reset_proc_rst_drop got %b want 0", proc_rst); end
    endtask

    task automatic test_capture();
        logic [8:0] want;
        frame = 9'h0A5;
        frame_valid = 1'b1;
        exp_q.push_back(model_mask(9'h0A5, cur_len));
        tick();
        frame_valid = 1'b0;
        checks++; if (proc_rst !== 1'b1) begin errors++; $display("[TB] FAIL cap_proc_rst got %b want 1", proc_rst); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL cap_out_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 9'h0A5) begin errors++; $display("[TB] FAIL cap_out_data got %h want 0a5", out_data); end
        tick();
        checks++; if (proc_rst !== 1'b0) begin errors++; $display("[TB] FAIL cap_proc_rst_width got %b want 0", proc_rst); end
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++; if (out_valid !== 1'b1 || out_data !== want) begin
                errors++; $display("[TB] FAIL cap_drain got v=%b d=%h want v=1 d=%h", out_valid, out_data, want); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL cap_empty got %b want 0", out_valid); end
    endtask

    task automatic test_hold_level();
        logic [8:0] want;
        frame = 9'h033;
        frame_valid = 1'b1;
        exp_q.push_back(model_mask(9'h033, cur_len));
        for (int i = 0; i < 5; i++) tick();
        frame_valid = 1'b0;
        tick();
        send_frame(9'h144, 1'b1);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++; if (out_valid !== 1'b1 || out_data !== want) begin
                errors++; $display("[TB] FAIL hold_drain got v=%b d=%h want v=1 d=%h", out_valid, out_data, want); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_single_push got %b want 0", out_valid); end
    endtask

    task automatic test_config_apply();
        bit         early_ack;
        bit         busy_dropped;
        bit         got;
        int         n;
        logic [8:0] want;
        cfg_frame_length = 4'd7;
        cfg_parity = 1'b1;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("[TB] FAIL cfg_busy_set got %b want 1", cfg_busy); end
        early_ack = 0;
        busy_dropped = 0;
        for (int i = 0; i < 300; i++) begin
            Rx = (i % 100 == 99) ? 1'b0 : 1'b1;
            tick();
            if (cfg_ack) early_ack = 1;
            if (!cfg_busy) busy_dropped = 1;
        end
        checks++; if (early_ack || busy_dropped) begin
            errors++; $display("[TB] FAIL cfg_wait_idle got ack=%b drop=%b want 0 0", early_ack, busy_dropped); end
        checks++; if (frame_length !== 4'd8 || parity !== 1'b0) begin
            errors++; $display("[TB] FAIL cfg_unchanged got len=%0d par=%b want 8 0", frame_length, parity); end
        Rx = 1'b1;
        n = 0;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            n++;
            if (cfg_ack) got = 1;
        end
        checks++; if (!got || n != 176) begin errors++; $display("[TB] FAIL cfg_ack_latency got %0d want 176", n); end
        checks++; if (frame_length !== 4'd7 || parity !== 1'b1 || proc_rst !== 1'b1) begin
            errors++; $display("[TB] FAIL cfg_applied got len=%0d par=%b prst=%b want 7 1 1", frame_length, parity, proc_rst); end
        tick();
        checks++; if (cfg_ack !== 1'b0 || cfg_busy !== 1'b0 || proc_rst !== 1'b0) begin
            errors++; $display("[TB] FAIL cfg_pulse_end got ack=%b busy=%b prst=%b want 0 0 0", cfg_ack, cfg_busy, proc_rst); end
        cur_len = 7;
        send_frame(9'h1FF, 1'b1);
        out_ready = 1'b1;
        want = exp_q.pop_front();
        checks++; if (out_data !== 9'h07F || want !== 9'h07F) begin
            errors++; $display("[TB] FAIL cfg_masked_frame got %h want 07f", out_data); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_cfg_error();
        logic [3:0] bad [2];
        bad[0] = 4'd4;
        bad[1] = 4'd10;
        foreach (bad[k]) begin
            cfg_frame_length = bad[k];
            cfg_parity = 1'b0;
            cfg_req = 1'b1;
            tick();
            cfg_req = 1'b0;
            checks++; if (cfg_err !== 1'b1 || cfg_busy !== 1'b0) begin
                errors++; $display("[TB] FAIL cfg_err_len%0d got err=%b busy=%b want 1 0", bad[k], cfg_err, cfg_busy); end
            tick();
            checks++; if (cfg_err !== 1'b0 || frame_length !== 4'd7 || parity !== 1'b1) begin
                errors++; $display("[TB] FAIL cfg_err_after%0d got err=%b len=%0d par=%b want 0 7 1", bad[k], cfg_err, frame_length, parity); end
        end
    endtask

    task automatic test_overrun();
        logic [8:0] f;
        logic [8:0] want;
        for (int i = 0; i < 8; i++) begin
            f = 9'($urandom_range(0, 511));
            send_frame(f, 1'b1);
        end
        checks++; if (overrun !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL ovr_fill got ovr=%b v=%b want 0 1", overrun, out_valid); end
        send_frame(9'h155, 1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set got %b want 1", overrun); end
        // Push into a full FIFO while the head is popped on the same edge.
        want = exp_q.pop_front();
        checks++; if (out_data !== want) begin errors++; $display("[TB] FAIL ovr_head got %h want %h", out_data, want); end
        frame = 9'h0C3;
        frame_valid = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(model_mask(9'h0C3, cur_len));
        tick();
        frame_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_clr got %b want 0", overrun); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h000;
            checks++; if (out_valid !== 1'b1 || out_data !== want) begin
                errors++; $display("[TB] FAIL ovr_drain%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, want); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovr_count got %b want 0", out_valid); end
    endtask

    task automatic test_reset_in_wait();
        bit ack_seen;
        for (int i = 0; i < 3; i++) send_frame(9'(i + 9'h011), 1'b1);
        cfg_frame_length = 4'd6;
        cfg_parity = 1'b1;
        cfg_req = 1'b1;
        tick();
        cfg_req = 1'b0;
        checks++; if (cfg_busy !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL rstw_pre got busy=%b v=%b want 1 1", cfg_busy, out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        cur_len = 8;
        checks++; if (out_valid !== 1'b0 || cfg_busy !== 1'b0 || frame_length !== 4'd8 || parity !== 1'b0) begin
            errors++; $display("[TB] FAIL rstw_post got v=%b busy=%b len=%0d par=%b want 0 0 8 0", out_valid, cfg_busy, frame_length, parity); end
        ack_seen = 0;
        Rx = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (cfg_ack || cfg_busy) ack_seen = 1;
        end
        checks++; if (ack_seen) begin errors++; $display("[TB] FAIL rstw_no_apply got 1 want 0"); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_hold_level();
        test_config_apply();
        test_cfg_error();
        test_overrun();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
